// File: rtl/pong_vga_pkg.sv
// Shared constants and types for the pong VGA pixel path: raster geometry
// defaults, coordinate width, the motion block's reset position and the
// coordinate clamp helper used when BALL_CLAMP_EN is defined.
package pong_vga_pkg;

  localparam int COORD_W        = 11;
  localparam int RGB_W          = 12;
  localparam int H_ACTIVE_DEF   = 800;
  localparam int V_ACTIVE_DEF   = 600;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  localparam coord_t RST_X   = coord_t'(395);
  localparam coord_t RST_Y   = coord_t'(0);
  localparam pos_t   RST_POS = '{x: RST_X, y: RST_Y};

  // Clamp one coordinate into [lo, hi]. A value with its two top bits set is
  // the wrapped result of a subtraction below zero, so it goes to the low
  // bound instead of being read as a huge positive number.
  function automatic coord_t clamp_coord(input coord_t v, input coord_t lo,
                                         input coord_t hi);
    if (v[COORD_W-1:COORD_W-2] == 2'b11) return lo;
    else if (v < lo)                     return lo;
    else if (v > hi)                     return hi;
    else                                 return v;
  endfunction

endpackage

// File: rtl/ball_disc_cmp.sv
// Disc membership test: stage 1 registers the signed offsets of the raster
// position from the ball centre, stage 2 forms the squared distance and
// compares it against the squared radius. hit is valid one clock after the
// inputs; the caller registers it to complete the second stage.
module ball_disc_cmp
  import pong_vga_pkg::*;
#(
  parameter int BALL_R = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  coord_t raster_x,
  input  coord_t raster_y,
  input  coord_t centre_x,
  input  coord_t centre_y,
  input  logic   video_on,
  output logic   hit
);

  localparam logic [23:0] R_SQ = 24'(BALL_R * BALL_R);

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic               video_on_d1;

  logic signed [23:0] dx_w;
  logic signed [23:0] dy_w;
  logic        [23:0] dist_sq;

  // Stage 1: offsets from the centre, with video_on kept in step.
  always_ff @(posedge clk) begin
    // NOTE: pipeline registers are reset too, so a stale "visible" flag from
    // before reset can never produce a ball pixel in the first cycles after it.
    if (rst) begin
      dx          <= '0;
      dy          <= '0;
      video_on_d1 <= 1'b0;
    end else begin
      dx          <= $signed({1'b0, raster_x} - {1'b0, centre_x});
      dy          <= $signed({1'b0, raster_y} - {1'b0, centre_y});
      video_on_d1 <= video_on;
    end
  end

  // Stage 2: squared distance; |dx|,|dy| <= 2047 so the sum fits in 24 bits.
  always_comb begin
    dx_w    = 24'(dx);
    dy_w    = 24'(dy);
    dist_sq = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);
    hit     = (dist_sq <= R_SQ) && video_on_d1;
  end

endmodule

// File: rtl/ball_renderer.sv
// Ball renderer: latches ball positions from the motion block, commits them
// once per frame at the start of vertical blank, and flags raster pixels that
// fall inside the ball disc with a fixed 2-clock latency.
// Optional build macro BALL_CLAMP_EN: clamp the committed centre so the whole
// disc stays on screen.
module ball_renderer
  import pong_vga_pkg::*;
#(
  parameter int                BALL_R   = 8,
  parameter int                H_ACTIVE = H_ACTIVE_DEF,
  parameter int                V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [RGB_W-1:0]  BALL_RGB = 12'hFFF
) (
  input  logic               clk,
  input  logic               rst_n,       // synchronous, active-high
  input  logic [COORD_W-1:0] new_x,
  input  logic [COORD_W-1:0] new_y,
  input  logic               loc_valid,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               video_on,
  output logic               frame_done,
  output logic               ball_pixel,
  output logic [RGB_W-1:0]   ball_rgb,
  output logic [COORD_W-1:0] disp_x,
  output logic [COORD_W-1:0] disp_y
);

  // Reject geometries where the disc cannot fit inside the visible area.
  if (BALL_R < 1 || BALL_R > 63 || H_ACTIVE <= 2 * BALL_R ||
      V_ACTIVE <= 2 * BALL_R) begin : g_bad_cfg
    $error("ball_renderer: unsupported BALL_R/H_ACTIVE/V_ACTIVE combination");
  end

  localparam coord_t V_COMMIT = coord_t'(V_ACTIVE);

  pos_t pending;
  pos_t committed;
  pos_t commit_pos;
  logic commit;
  logic hit;

  // First pixel of the first vblank line: the raster is off-screen, so the
  // displayed centre can change here without tearing a visible frame.
  assign commit = (hcount == '0) && (vcount == V_COMMIT);

`ifdef BALL_CLAMP_EN
  localparam coord_t X_LO = coord_t'(BALL_R);
  localparam coord_t X_HI = coord_t'(H_ACTIVE - 1 - BALL_R);
  localparam coord_t Y_LO = coord_t'(BALL_R);
  localparam coord_t Y_HI = coord_t'(V_ACTIVE - 1 - BALL_R);

  // Keep the whole disc on screen.
  always_comb begin
    commit_pos.x = clamp_coord(pending.x, X_LO, X_HI);
    commit_pos.y = clamp_coord(pending.y, Y_LO, Y_HI);
  end
`else
  // Commit the raw position; an off-screen centre simply draws less.
  always_comb begin
    commit_pos = pending;
  end
`endif

  // Position capture and frame-boundary commit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pending    <= RST_POS;
      committed  <= RST_POS;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean a strobe landing on the commit cycle
      // writes pending while committed still takes pending's old value.
      if (loc_valid) pending <= '{x: new_x, y: new_y};
      if (commit)    committed <= commit_pos;
      frame_done <= commit;
    end
  end

  ball_disc_cmp #(
    .BALL_R (BALL_R)
  ) u_disc (
    .clk      (clk),
    .rst      (rst_n),
    .raster_x (hcount),
    .raster_y (vcount),
    .centre_x (committed.x),
    .centre_y (committed.y),
    .video_on (video_on),
    .hit      (hit)
  );

  // Second pipeline stage: register the hit flag and the colour it selects.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ball_pixel <= 1'b0;
      ball_rgb   <= '0;
    end else begin
      ball_pixel <= hit;
      ball_rgb   <= hit ? BALL_RGB : '0;
    end
  end

  assign disp_x = committed.x;
  assign disp_y = committed.y;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: raster positions are driven directly
// (no full VGA timing) so each frame boundary is a single commit cycle.
// Expected values are hand-computed from the disc rule dx^2+dy^2 <= 64.
`timescale 1ns/1ps
module tb_ball_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] new_x, new_y;
  logic        loc_valid;
  logic [10:0] hcount, vcount;
  logic        video_on;
  logic        frame_done;
  logic        ball_pixel;
  logic [11:0] ball_rgb;
  logic [10:0] disp_x, disp_y;

  int checks = 0;
  int errors = 0;

  ball_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_x      (new_x),
    .new_y      (new_y),
    .loc_valid  (loc_valid),
    .hcount     (hcount),
    .vcount     (vcount),
    .video_on   (video_on),
    .frame_done (frame_done),
    .ball_pixel (ball_pixel),
    .ball_rgb   (ball_rgb),
    .disp_x     (disp_x),
    .disp_y     (disp_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raster parked in vblank, away from the commit point.
  task automatic idle();
    hcount   = 11'd5;
    vcount   = 11'd650;
    video_on = 1'b0;
  endtask

  task automatic strobe(input int x, input int y);
    new_x     = 11'(x);
    new_y     = 11'(y);
    loc_valid = 1'b1;
    tick();
    loc_valid = 1'b0;
  endtask

  // Present the commit cycle, then one more cycle to see the pulse end.
  task automatic do_commit(input string tag);
    hcount   = 11'd0;
    vcount   = 11'd600;
    video_on = 1'b0;
    tick();
    check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    idle();
    tick();
    check({tag, "_frame_done_end"}, 32'(frame_done), 32'd0);
  endtask

  // Present one raster pixel and compare the result two clocks later.
  task automatic probe(input string tag, input int x, input int y,
                       input logic von, input logic exp_hit);
    hcount   = 11'(x);
    vcount   = 11'(y);
    video_on = von;
    tick();
    idle();
    tick();
    check({tag, "_pixel"}, 32'(ball_pixel), 32'(exp_hit));
    check({tag, "_rgb"},   32'(ball_rgb),   exp_hit ? 32'hFFF : 32'h0);
  endtask

  initial begin
    rst_n     = 1'b1;
    new_x     = '0;
    new_y     = '0;
    loc_valid = 1'b0;
    idle();
    repeat (3) tick();

    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pixel",      32'(ball_pixel), 32'd0);
    check("rst_rgb",        32'(ball_rgb),   32'd0);
    check("rst_disp_x",     32'(disp_x),     32'd395);
    check("rst_disp_y",     32'(disp_y),     32'd0);

    rst_n = 1'b0;
    tick();

    // Reset position: centre (395,0).
    probe("c0", 395, 0, 1'b1, 1'b1);
    probe("c8", 395, 8, 1'b1, 1'b1);
    probe("c9", 395, 9, 1'b1, 1'b0);
    probe("blank", 395, 0, 1'b0, 1'b0);

    // Latency: after one clock the result has not yet reached the output.
    hcount = 11'd395; vcount = 11'd0; video_on = 1'b1;
    tick();
    idle();
    check("lat_1clk", 32'(ball_pixel), 32'd0);
    tick();
    check("lat_2clk", 32'(ball_pixel), 32'd1);
    tick();

    do_commit("f0");
    check("f0_disp_x", 32'(disp_x), 32'd395);
    check("f0_disp_y", 32'(disp_y), 32'd0);

    // Mid-frame strobe does not disturb the frame being drawn.
    strobe(100, 200);
    check("mid_disp_x", 32'(disp_x), 32'd395);
    probe("mid_old", 395, 0, 1'b1, 1'b1);
    probe("mid_new", 100, 200, 1'b1, 1'b0);
    do_commit("f1");
    check("f1_disp_x", 32'(disp_x), 32'd100);
    check("f1_disp_y", 32'(disp_y), 32'd200);
    probe("p108", 108, 200, 1'b1, 1'b1);
    probe("p109", 109, 200, 1'b1, 1'b0);
    probe("p106_206", 106, 206, 1'b1, 1'b0);  // 36+36=72 > 64
    probe("p104_206", 104, 206, 1'b1, 1'b1);  // 16+36=52
    probe("p92", 92, 200, 1'b1, 1'b1);
    probe("p91", 91, 200, 1'b1, 1'b0);

    // Last strobe before the commit wins.
    strobe(50, 50);
    strobe(60, 60);
    do_commit("f2");
    check("f2_disp_x", 32'(disp_x), 32'd60);
    check("f2_disp_y", 32'(disp_y), 32'd60);

    // Strobe in the commit cycle itself is deferred one frame.
    hcount = 11'd0; vcount = 11'd600; video_on = 1'b0;
    new_x = 11'd300; new_y = 11'd300; loc_valid = 1'b1;
    tick();
    loc_valid = 1'b0;
    check("co_frame_done", 32'(frame_done), 32'd1);
    check("co_disp_x", 32'(disp_x), 32'd60);
    check("co_disp_y", 32'(disp_y), 32'd60);
    idle();
    tick();
    do_commit("f3");
    check("f3_disp_x", 32'(disp_x), 32'd300);
    check("f3_disp_y", 32'(disp_y), 32'd300);

    // Off-screen x (wrapped negative) near the bottom edge.
    strobe(2040, 590);
    do_commit("f4");
`ifdef BALL_CLAMP_EN
    check("f4_disp_x", 32'(disp_x), 32'd8);
    // 590 already lies inside [8,591], so y passes through.
    check("f4_disp_y", 32'(disp_y), 32'd590);
    probe("edge_col0", 0, 590, 1'b1, 1'b1);
    probe("edge_col7", 7, 590, 1'b1, 1'b1);
    strobe(100, 599);
    do_commit("f4b");
    check("f4b_disp_y", 32'(disp_y), 32'd591);
`else
    check("f4_disp_x", 32'(disp_x), 32'd2040);
    check("f4_disp_y", 32'(disp_y), 32'd590);
    for (int c = 0; c < 8; c++) begin
      probe($sformatf("edge_col%0d", c), c, 590, 1'b1, 1'b0);
    end
`endif

    // Reset in the middle of a visible run of ball pixels.
    strobe(300, 300);
    do_commit("f5");
    hcount = 11'd300; vcount = 11'd300; video_on = 1'b1;
    tick();
    tick();
    check("pre_rst_pixel", 32'(ball_pixel), 32'd1);
    rst_n = 1'b1;
    tick();
    check("mrst_pixel",      32'(ball_pixel), 32'd0);
    check("mrst_rgb",        32'(ball_rgb),   32'd0);
    check("mrst_disp_x",     32'(disp_x),     32'd395);
    check("mrst_disp_y",     32'(disp_y),     32'd0);
    check("mrst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b0;
    tick();
    // Raster still at (300,300), now far from the reset centre.
    check("post_rst_pixel", 32'(ball_pixel), 32'd0);
    idle();
    tick();
    probe("post_rst_c0", 395, 0, 1'b1, 1'b1);
    // Pending was reset too, so the next commit keeps (395,0).
    do_commit("f6");
    check("f6_disp_x", 32'(disp_x), 32'd395);
    check("f6_disp_y", 32'(disp_y), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
